// File: rtl/alu_nibble_sequencer.sv
// Purpose: time-shares an external 4-bit ALU between two requesters and runs W-bit ADD/SUB/AND/NOT one nibble per pass, LSB nibble first.
// Latency: the accept cycle plus NIB pass cycles, then rsp_valid rises. Throughput is one op every NIB+2 cycles.
// Backpressure: the response holds stable in DONE until rsp_ready. Requests are accepted only in IDLE, with round-robin arbitration on contention.
module alu_nibble_sequencer #(
    parameter int NIB     = 2,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_op,
    input  logic [4*NIB-1:0]     req0_a,
    input  logic [4*NIB-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_op,
    input  logic [4*NIB-1:0]     req1_a,
    input  logic [4*NIB-1:0]     req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [4*NIB-1:0]     rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_ovf,
    output logic [2:0]           alu_select,
    output logic                 alu_in_c,
    output logic [3:0]           alu_in_x,
    output logic [3:0]           alu_in_y,
    input  logic [3:0]           alu_out_s,
    input  logic                 alu_out_c
);

    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] sel;
        logic       in_c;
        logic [3:0] y;
    } alu_drv_t;

    state_t                 state;
    logic                   rr_q;
    logic [CW-1:0]          cnt;
    logic [1:0]             op_q;
    logic [NIB-1:0][3:0]    a_q;
    logic [NIB-1:0][3:0]    b_q;
    logic [NIB-1:0][3:0]    res_q;
    logic                   id_q;

    logic                   grant;
    logic                   accept;
    logic [1:0]             op_sel;
    logic [NIB-1:0][3:0]    a_sel;
    logic [NIB-1:0][3:0]    b_sel;
    logic [NIB-1:0][3:0]    res_next;
    logic [CW-1:0]          nxt;
    logic                   arith;
    logic                   ovf_next;
    alu_drv_t               drv_first;
    alu_drv_t               drv_next;

    // ALU control for one nibble pass. The chained carry (c) from the previous
    // pass picks between the plain-add and add-plus-one encodings. A borrow
    // on SUB is folded in by adding ~b without the +1.
    function automatic alu_drv_t nibble_drive(input logic [1:0] op,
                                              input logic       first,
                                              input logic       c,
                                              input logic [3:0] b_nib);
        alu_drv_t d;
        d      = '0;
        d.y    = b_nib;
        case (op)
            OP_ADD: d.sel = (!first && c) ? 3'b001 : 3'b000;
            OP_SUB: begin
                if (first || c) begin
                    d.sel  = 3'b001;
                    d.in_c = 1'b1;
                end else begin
                    d.sel = 3'b000;
                    d.y   = ~b_nib;
                end
            end
            OP_AND: d.sel = 3'b011;
            OP_NOT: begin
                d.sel = 3'b010;
                d.y   = 4'h0;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    // Arbitration, request mux, and the result as it will look after this pass.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? rr_q : req1_valid;
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        op_sel     = grant ? req1_op : req0_op;
        a_sel      = grant ? req1_a  : req0_a;
        b_sel      = grant ? req1_b  : req0_b;
        drv_first  = nibble_drive(op_sel, 1'b1, 1'b0, b_sel[0]);
        nxt        = cnt + 1'b1;
        drv_next   = nibble_drive(op_q, 1'b0, alu_out_c, b_q[nxt]);
        res_next   = res_q;
        res_next[cnt] = alu_out_s;
        arith      = (op_q == OP_ADD) || (op_q == OP_SUB);
        ovf_next   = 1'b0;
        if (op_q == OP_ADD)
            ovf_next = (a_q[NIB-1][3] == b_q[NIB-1][3]) && (res_next[NIB-1][3] != a_q[NIB-1][3]);
        else if (op_q == OP_SUB)
            ovf_next = (a_q[NIB-1][3] != b_q[NIB-1][3]) && (res_next[NIB-1][3] != a_q[NIB-1][3]);
    end

    // Sequencer FSM. The ALU drive for pass k is registered one cycle ahead,
    // so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_q       <= RR_INIT;
            cnt        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
            alu_select <= 3'b000;
            alu_in_c   <= 1'b0;
            alu_in_x   <= 4'h0;
            alu_in_y   <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= op_sel;
                        a_q        <= a_sel;
                        b_q        <= b_sel;
                        id_q       <= grant;
                        rr_q       <= ~grant;
                        cnt        <= '0;
                        res_q      <= '0;
                        alu_select <= drv_first.sel;
                        alu_in_c   <= drv_first.in_c;
                        alu_in_x   <= a_sel[0];
                        alu_in_y   <= drv_first.y;
                        state      <= PASS;
                    end
                end
                PASS: begin
                    res_q <= res_next;
                    if (cnt == LAST) begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= id_q;
                        rsp_result <= res_next;
                        rsp_carry  <= arith & alu_out_c;
                        rsp_zero   <= (res_next == '0);
                        rsp_ovf    <= ovf_next;
                        alu_select <= 3'b000;
                        alu_in_c   <= 1'b0;
                        alu_in_x   <= 4'h0;
                        alu_in_y   <= 4'h0;
                        state      <= DONE;
                    end else begin
                        cnt        <= nxt;
                        alu_select <= drv_next.sel;
                        alu_in_c   <= drv_next.in_c;
                        alu_in_x   <= a_q[nxt];
                        alu_in_y   <= drv_next.y;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
module tb_alu_nibble_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_ovf;
    logic [7:0] rsp_result;
    logic [2:0] alu_select;
    logic       alu_in_c, alu_out_c;
    logic [3:0] alu_in_x, alu_in_y, alu_out_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIB(2), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_ovf(rsp_ovf),
        .alu_select(alu_select), .alu_in_c(alu_in_c), .alu_in_x(alu_in_x),
        .alu_in_y(alu_in_y), .alu_out_s(alu_out_s), .alu_out_c(alu_out_c)
    );

    // External 4-bit ALU: 000 x+y, 001 x+(in_c ? ~y : y)+1, 010 ~x, 011 x&y.
    always_comb begin
        {alu_out_c, alu_out_s} = 5'd0;
        case (alu_select)
            3'b000: {alu_out_c, alu_out_s} = {1'b0, alu_in_x} + {1'b0, alu_in_y};
            3'b001: {alu_out_c, alu_out_s} = {1'b0, alu_in_x} + {1'b0, (alu_in_c ? ~alu_in_y : alu_in_y)} + 5'd1;
            3'b010: alu_out_s = ~alu_in_x;
            3'b011: alu_out_s = alu_in_x & alu_in_y;
            default: ;
        endcase
    end

    typedef struct {
        logic       id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       o;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_flags"}, {rsp_id, rsp_carry, rsp_zero, rsp_ovf}, 0);
        chk({tag, "_alu"}, {alu_select, alu_in_c, alu_in_x, alu_in_y}, 0);
        chk({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    endtask

    // Issue one op on requester v.id and check the response and its latency.
    task automatic run_op(input string name, input vec_t v);
        bit got;
        int n;
        @(negedge clk);
        if (v.id == 1'b0) begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end else begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if ((v.id == 1'b0 && req0_ready) || (v.id == 1'b1 && req1_ready)) got = 1'b1;
            else @(negedge clk);
        end
        chk({name, "_accept"}, got, 1);
        if (!got) begin
            drop_reqs();
            return;
        end
        chk({name, "_other_ready"}, (v.id ? req0_ready : req1_ready), 0);
        @(posedge clk);
        @(negedge clk);
        drop_reqs();
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n + 1, 3);
        chk({name, "_result"}, rsp_result, v.res);
        chk({name, "_carry"}, rsp_carry, v.c);
        chk({name, "_zero"}, rsp_zero, v.z);
        chk({name, "_ovf"}, rsp_ovf, v.o);
        chk({name, "_id"}, rsp_id, v.id);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, "_valid_clear"}, rsp_valid, 0);
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        int n, r0cnt, r1cnt, nrsp;
        logic [3:0] ids;
        bit seen;

        rst_n = 1'b0; rsp_ready = 1'b0;
        drop_reqs();

        //           id    op     a      b      res    c     z     o
        vecs[0] = '{1'b0, 2'b00, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 2'b01, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 2'b10, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 2'b11, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 2'b01, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // Round robin from a fresh reset: both requesters valid throughout.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h01; req0_b = 8'h01;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'h01; req1_b = 8'h01;
        rsp_ready = 1'b1;
        r0cnt = 0; r1cnt = 0; nrsp = 0; ids = 4'h0;
        for (int i = 0; i < 60 && nrsp < 4; i++) begin
            #1;
            if (req0_ready) r0cnt++;
            if (req1_ready) r1cnt++;
            if (rsp_valid) begin
                ids[nrsp] = rsp_id;
                nrsp++;
            end
            @(negedge clk);
        end
        chk("rr_rsp_count", nrsp, 4);
        chk("rr_id_seq", ids, 4'b1010);
        chk("rr_ready0_pulses", r0cnt, 2);
        chk("rr_ready1_pulses", r1cnt, 2);
        rsp_ready = 1'b0;
        drop_reqs();
        repeat (4) @(negedge clk);

        // Response held under backpressure while another request waits.
        v = '{1'b0, 2'b00, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0};
        req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        #1;
        chk("hold_accept", req0_ready, 1);
        @(negedge clk);
        drop_reqs();
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_latency", n + 1, 3);
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("hold%0d_rsp", i), {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_ovf},
                {1'b1, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0});
            chk($sformatf("hold%0d_ready", i), {req0_ready, req1_ready}, 0);
        end
        drop_reqs();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_release", rsp_valid, 0);

        // Asynchronous reset during the second pass drops the op.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h11; req0_b = 8'h22;
        #1;
        chk("rst_accept", req0_ready, 1);
        @(negedge clk);
        drop_reqs();
        @(negedge clk);
        chk("rst_pass1_x", alu_in_x, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", seen, 0);
        run_op("after_rst", '{1'b0, 2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
